// File: rtl/sc_fifo.sv
// -----------------------------------------------------------------------------
// sc_fifo -- parametrised single-clock FIFO
//
// Purpose:
//   Same-domain buffering of decoder data (bitstream words, residual and
//   intra-prediction data). All 2^addr_bits slots are usable because the
//   pointers carry one extra wrap bit. The FIFO provides:
//   - programmable almost-full and almost-empty flags;
//   - sticky overflow and underflow error flags;
//   - an optional first-word-fall-through read port.
//
// Build option:
//   SC_FIFO_FWFT_EN
//     Undefined: rd_data is registered and is valid one cycle after an
//     accepted rd. It holds its value otherwise.
//     Defined: rd_data shows the head word combinationally whenever
//     rd_empty=0, and rd acts as an acknowledge.
//
// Parameters:
//   data_bits      width of one FIFO word
//   addr_bits      log2 of the depth (depth = 1 << addr_bits)
//   afull_margin   wr_almost_full when free slots <= afull_margin
//   aempty_margin  rd_almost_empty when words_avail <= aempty_margin
//
// Ports:
//   clk              in   clock; all logic runs on its rising edge
//   rst              in   synchronous active-high reset
//   wr / wr_data     in   write request and the word to write
//   wr_full          out  words_avail == depth
//   wr_almost_full   out  words_avail >= depth - afull_margin
//   rd               in   read request (pop)
//   rd_data          out  read word (timing depends on SC_FIFO_FWFT_EN)
//   rd_empty         out  words_avail == 0
//   rd_almost_empty  out  words_avail <= aempty_margin
//   words_avail      out  occupancy, 0..depth
//   overflow         out  sticky: a write was attempted while full
//   underflow        out  sticky: a read was attempted while empty
// -----------------------------------------------------------------------------
module sc_fifo #(
  parameter int data_bits     = 16,
  parameter int addr_bits     = 7,
  parameter int afull_margin  = 4,
  parameter int aempty_margin = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [data_bits-1:0] wr_data,
  output logic                 wr_full,
  output logic                 wr_almost_full,
  input  logic                 rd,
  output logic [data_bits-1:0] rd_data,
  output logic                 rd_empty,
  output logic                 rd_almost_empty,
  output logic [addr_bits:0]   words_avail,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int depth = 1 << addr_bits;

  // Thresholds are held at the occupancy width, so the comparisons never
  // truncate.
  localparam logic [addr_bits:0] depth_cnt    = (addr_bits+1)'(depth);
  localparam logic [addr_bits:0] afull_level  = depth_cnt - (addr_bits+1)'(afull_margin);
  localparam logic [addr_bits:0] aempty_level = (addr_bits+1)'(aempty_margin);
  localparam logic [addr_bits:0] ptr_one      = (addr_bits+1)'(1);

  logic [data_bits-1:0] mem [depth];

  // Each pointer has one extra wrap bit. The difference between the two
  // pointers therefore separates full (depth) from empty (0) without a
  // spare slot.
  logic [addr_bits:0]   wr_ptr_reg;
  logic [addr_bits:0]   rd_ptr_reg;
  logic                 overflow_reg;
  logic                 underflow_reg;
  logic                 wr_accept;
  logic                 rd_accept;
  logic [addr_bits-1:0] wr_idx;
  logic [addr_bits-1:0] rd_idx;

  assign wr_idx = wr_ptr_reg[addr_bits-1:0];
  assign rd_idx = rd_ptr_reg[addr_bits-1:0];

  // Modulo subtraction of the pointers gives the occupancy.
  assign words_avail     = wr_ptr_reg - rd_ptr_reg;
  assign wr_full         = (words_avail == depth_cnt);
  assign wr_almost_full  = (words_avail >= afull_level);
  assign rd_empty        = (words_avail == '0);
  assign rd_almost_empty = (words_avail <= aempty_level);
  assign overflow        = overflow_reg;
  assign underflow       = underflow_reg;

  // The accept terms look only at the current occupancy. At the boundaries
  // this gives the required behaviour for a simultaneous wr and rd:
  //   full  -> the read is accepted and the write is rejected;
  //   empty -> the write is accepted and the read is rejected.
  // A write in the reset cycle is dropped.
  assign wr_accept = wr && !wr_full && !rst;
  assign rd_accept = rd && !rd_empty && !rst;

  // The RAM write port has no reset, so the array can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + ptr_one;
      end
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_reg + ptr_one;
      end
      // A rejected operation only sets its sticky flag.
      if (wr && wr_full) begin
        overflow_reg <= 1'b1;
      end
      if (rd && rd_empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

`ifdef SC_FIFO_FWFT_EN
  // The head word falls through combinationally. Its value is meaningless
  // while rd_empty=1.
  assign rd_data = mem[rd_idx];
`else
  // The output register loads only on an accepted read. It holds its value
  // through idle cycles and rejected reads.
  logic [data_bits-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (rd_accept) begin
      rd_data_reg <= mem[rd_idx];
    end
  end

  assign rd_data = rd_data_reg;
`endif

endmodule

// File: tb/tb_sc_fifo.sv
// -----------------------------------------------------------------------------
// tb_sc_fifo -- directed, self-checking bench for sc_fifo
//
// Configuration under test:
//   data_bits=16, addr_bits=2 (depth 4), afull_margin=1, aempty_margin=1.
//
// Reference model:
//   The bench keeps its own occupancy count, its own sticky flags and a
//   queue of accepted words.
//   - A word is pushed onto the queue when the bench drives a write that
//     the model accepts.
//   - A word is popped and compared when the DUT presents it. That is after
//     the edge in standard mode, and before the rd in FWFT mode.
// -----------------------------------------------------------------------------
module tb_sc_fifo;

  localparam int DB    = 16;
  localparam int AB    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr  = 1'b0;
  logic          rd  = 1'b0;
  logic [DB-1:0] wr_data = '0;
  logic          wr_full;
  logic          wr_almost_full;
  logic [DB-1:0] rd_data;
  logic          rd_empty;
  logic          rd_almost_empty;
  logic [AB:0]   words_avail;
  logic          overflow;
  logic          underflow;

  sc_fifo #(
    .data_bits     (DB),
    .addr_bits     (AB),
    .afull_margin  (1),
    .aempty_margin (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr              (wr),
    .wr_data         (wr_data),
    .wr_full         (wr_full),
    .wr_almost_full  (wr_almost_full),
    .rd              (rd),
    .rd_data         (rd_data),
    .rd_empty        (rd_empty),
    .rd_almost_empty (rd_almost_empty),
    .words_avail     (words_avail),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  string         phase  = "init";
  logic [DB-1:0] q[$];
  int            count  = 0;
  logic          m_ovf  = 1'b0;
  logic          m_udf  = 1'b0;
  logic [DB-1:0] last_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_status();
    check("words_avail",     32'(words_avail),     32'(count));
    check("wr_full",         32'(wr_full),         32'(count == DEPTH));
    check("wr_almost_full",  32'(wr_almost_full),  32'(count >= DEPTH - 1));
    check("rd_empty",        32'(rd_empty),        32'(count == 0));
    check("rd_almost_empty", 32'(rd_almost_empty), 32'(count <= 1));
    check("overflow",        32'(overflow),        32'(m_ovf));
    check("underflow",       32'(underflow),       32'(m_udf));
  endtask

  // Pulse reset for one cycle. A write may be driven in the same cycle; the
  // FIFO must drop it.
  task automatic do_reset(input logic w);
    rst     = 1'b1;
    wr      = w;
    wr_data = 16'hDEAD;
    rd      = 1'b0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    wr      = 1'b0;
    q.delete();
    count   = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    last_rd = '0;
`ifndef SC_FIFO_FWFT_EN
    check("rd_data_rst", 32'(rd_data), 32'(last_rd));
`endif
    check_status();
  endtask

  // Run one clock cycle with the given wr/rd request, then check all
  // outputs against the model.
  task automatic step(input logic w, input logic [DB-1:0] wd, input logic r);
    logic          w_acc;
    logic          r_acc;
    logic [DB-1:0] exp_rd;
    exp_rd  = '0;
    w_acc   = w && (count < DEPTH);
    r_acc   = r && (count > 0);
    wr      = w;
    wr_data = wd;
    rd      = r;
    if (r_acc) exp_rd = q.pop_front();
`ifdef SC_FIFO_FWFT_EN
    if (r_acc) check("head", 32'(rd_data), 32'(exp_rd));
`endif
    if (w_acc) q.push_back(wd);
    if (w && !w_acc) m_ovf = 1'b1;
    if (r && !r_acc) m_udf = 1'b1;
    count = count + int'(w_acc) - int'(r_acc);
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
`ifndef SC_FIFO_FWFT_EN
    if (r_acc) last_rd = exp_rd;
    check("rd_data", 32'(rd_data), 32'(last_rd));
`endif
    check_status();
  endtask

  initial begin
    phase = "reset";
    do_reset(1'b0);

    phase = "fill";
    step(1'b1, 16'h0011, 1'b0);
    step(1'b1, 16'h0022, 1'b0);
    step(1'b1, 16'h0033, 1'b0);
    step(1'b1, 16'h0044, 1'b0);
    step(1'b1, 16'h0055, 1'b0);

    phase = "drain";
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    phase = "wrap";
    step(1'b1, 16'd1, 1'b0);
    for (int v = 2; v <= 6; v++) step(1'b1, 16'(v), 1'b1);
    step(1'b0, '0, 1'b1);

    phase = "full_wr_rd";
    do_reset(1'b0);
    for (int v = 0; v < DEPTH; v++) step(1'b1, 16'h0100 + 16'(v), 1'b0);
    step(1'b1, 16'h0BAD, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1);

    phase = "empty_wr_rd";
    step(1'b1, 16'hABCD, 1'b1);
    step(1'b0, '0, 1'b1);

    phase = "mid_reset";
    do_reset(1'b0);
    step(1'b1, 16'h0A01, 1'b0);
    step(1'b1, 16'h0A02, 1'b0);
    step(1'b1, 16'h0A03, 1'b0);
    do_reset(1'b1);
    step(1'b1, 16'h7777, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
